exec_alu_unit: RTL and testbench

- Execute-stage arithmetic block for the 5-stage pipelined processor.
- Decodes the 2-bit main-control ALUop and the R-type funct field into a 6-bit ALU operation, and computes a 32-bit result with zero/carry/overflow flags.
- Registers result, flags and branch request across the EX/MEM boundary.
- Produces the branch-taken signal (branch AND zero) used by PC selection.

---
 rtl/exec_alu_unit.sv | 154 +++++++++++++++
 tb/tb_exec_alu_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/exec_alu_unit.sv
// Execute-stage ALU for the 5-stage pipeline.
// Decodes ALUop/funct into a 6-bit operation and computes a result with
// zero/carry/overflow flags. Result, flags and the branch request are
// registered across the EX/MEM boundary. do_branch (branch AND zero) comes
// from the registered copies.
module exec_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             branch,
  output logic [5:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic [WIDTH-1:0] mem_result,
  output logic [2:0]       mem_flags,
  output logic             mem_branch,
  output logic             do_branch
);

  localparam int SHW = $clog2(WIDTH);

  // Operation encodings seen by the ALU
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000001;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_XOR  = 6'b000011;
  localparam logic [5:0] OP_SUB  = 6'b000110;
  localparam logic [5:0] OP_SLT  = 6'b000111;
  localparam logic [5:0] OP_NOR  = 6'b001100;
  localparam logic [5:0] OP_SLL  = 6'b001000;
  localparam logic [5:0] OP_SRL  = 6'b001001;
  localparam logic [5:0] OP_SRA  = 6'b001010;
  localparam logic [5:0] OP_SLTU = 6'b001011;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  logic [5:0]       w_operation;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;
  logic             w_zero;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_slt;
  logic             w_sltu;
  logic [SHW-1:0]   w_shamt;

  logic [WIDTH-1:0] r_mem_result;
  logic [2:0]       r_mem_flags;
  logic             r_mem_branch;

  // Extra top bit captures the carry out of ADD and the borrow of SUB
  assign w_sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign w_diff = {1'b0, operand_a} - {1'b0, operand_b};

  // ADD overflows when like-signed operands give a differently signed sum;
  // SUB overflows when operand signs differ and the result sign leaves a's
  assign w_add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
  assign w_sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != operand_a[WIDTH-1]);

  assign w_slt   = ($signed(operand_a) < $signed(operand_b));
  assign w_sltu  = (operand_a < operand_b);
  assign w_shamt = operand_a[SHW-1:0];

  // ALU control: main ALUop selects a fixed op or defers to the funct field
  always_comb begin
    w_operation = OP_NOP;
    case (alu_op)
      2'b00: w_operation = OP_ADD;
      2'b01: w_operation = OP_SUB;
      2'b11: w_operation = OP_OR;
      2'b10: begin
        case (funct)
          6'b100000: w_operation = OP_ADD;
          6'b100001: w_operation = OP_ADD;
          6'b100010: w_operation = OP_SUB;
          6'b100011: w_operation = OP_SUB;
          6'b100100: w_operation = OP_AND;
          6'b100101: w_operation = OP_OR;
          6'b100110: w_operation = OP_XOR;
          6'b100111: w_operation = OP_NOR;
          6'b101010: w_operation = OP_SLT;
          6'b101011: w_operation = OP_SLTU;
          6'b000100: w_operation = OP_SLL;
          6'b000110: w_operation = OP_SRL;
          6'b000111: w_operation = OP_SRA;
          default:   w_operation = OP_NOP;
        endcase
      end
      default: w_operation = OP_NOP;
    endcase
  end

  // ALU datapath plus carry/overflow; only ADD and SUB produce carry/overflow
  always_comb begin
    w_result   = {WIDTH{1'b0}};
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (w_operation)
      OP_ADD: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = w_add_ovf;
      end
      OP_SUB: begin
        w_result   = w_diff[WIDTH-1:0];
        w_carry    = ~w_diff[WIDTH];
        w_overflow = w_sub_ovf;
      end
      OP_AND:  w_result = operand_a & operand_b;
      OP_OR:   w_result = operand_a | operand_b;
      OP_XOR:  w_result = operand_a ^ operand_b;
      OP_NOR:  w_result = ~(operand_a | operand_b);
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_SLL:  w_result = operand_b << w_shamt;
      OP_SRL:  w_result = operand_b >> w_shamt;
      OP_SRA:  w_result = $signed(operand_b) >>> w_shamt;
      default: w_result = {WIDTH{1'b0}};
    endcase
  end

  assign w_zero = (w_result == {WIDTH{1'b0}});

  // EX/MEM pipeline register: loads every cycle, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_result <= {WIDTH{1'b0}};
      r_mem_flags  <= 3'b000;
      r_mem_branch <= 1'b0;
    end else begin
      r_mem_result <= w_result;
      r_mem_flags  <= {w_zero, w_carry, w_overflow};
      r_mem_branch <= branch;
    end
  end

  assign operation  = w_operation;
  assign result     = w_result;
  assign flags      = {w_zero, w_carry, w_overflow};
  assign mem_result = r_mem_result;
  assign mem_flags  = r_mem_flags;
  assign mem_branch = r_mem_branch;
  assign do_branch  = r_mem_branch & r_mem_flags[2];

endmodule

// File: tb/tb_exec_alu_unit.sv
// Self-checking bench for exec_alu_unit: table of vectors with hand-computed
// expectations, combinational checks right after driving, and a scoreboard
// queue for the registered EX/MEM outputs one clock later.
module tb_exec_alu_unit;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic [5:0]  eop;
    logic [31:0] eres;
    logic [2:0]  efl;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
    logic        br;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        branch;
  logic [5:0]  operation;
  logic [31:0] result;
  logic [2:0]  flags;
  logic [31:0] mem_result;
  logic [2:0]  mem_flags;
  logic        mem_branch;
  logic        do_branch;

  int total;
  int bad;
  vec_t vecs[$];
  sb_t  sbq[$];

  exec_alu_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op),
    .funct      (funct),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .branch     (branch),
    .operation  (operation),
    .result     (result),
    .flags      (flags),
    .mem_result (mem_result),
    .mem_flags  (mem_flags),
    .mem_branch (mem_branch),
    .do_branch  (do_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] f,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic br, input logic [5:0] eop,
                              input logic [31:0] eres, input logic [2:0] efl);
    vec_t v;
    v.op = op; v.f = f; v.a = a; v.b = b; v.br = br;
    v.eop = eop; v.eres = eres; v.efl = efl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector, check combinational outputs, then check the register a clock later
  task automatic apply(input vec_t v, input int idx);
    sb_t e;
    sb_t g;
    alu_op = v.op; funct = v.f; operand_a = v.a; operand_b = v.b; branch = v.br;
    #1;
    chk($sformatf("v%0d operation", idx), {26'd0, operation}, {26'd0, v.eop});
    chk($sformatf("v%0d result", idx), result, v.eres);
    chk($sformatf("v%0d flags", idx), {29'd0, flags}, {29'd0, v.efl});
    e.res = v.eres; e.fl = v.efl; e.br = v.br;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk($sformatf("v%0d mem_result", idx), mem_result, g.res);
    chk($sformatf("v%0d mem_flags", idx), {29'd0, mem_flags}, {29'd0, g.fl});
    chk($sformatf("v%0d mem_branch", idx), {31'd0, mem_branch}, {31'd0, g.br});
    chk($sformatf("v%0d do_branch", idx), {31'd0, do_branch}, {31'd0, g.br & g.fl[2]});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    alu_op = 2'b00; funct = 6'b000000; operand_a = 32'd0; operand_b = 32'd0; branch = 1'b0;

    //        op     funct      a             b             br    op        result        flags
    vecs.push_back(mk(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 6'b000010, 32'h80000000, 3'b001));
    vecs.push_back(mk(2'b01, 6'b000000, 32'h00001234, 32'h00001234, 1'b1, 6'b000110, 32'h00000000, 3'b110));
    vecs.push_back(mk(2'b01, 6'b000000, 32'h00001235, 32'h00001234, 1'b1, 6'b000110, 32'h00000001, 3'b010));
    vecs.push_back(mk(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 6'b000111, 32'h00000001, 3'b000));
    vecs.push_back(mk(2'b10, 6'b101011, 32'hFFFFFFFF, 32'h00000001, 1'b1, 6'b001011, 32'h00000000, 3'b100));
    vecs.push_back(mk(2'b10, 6'b000111, 32'h00000004, 32'h80000000, 1'b0, 6'b001010, 32'hF8000000, 3'b000));
    vecs.push_back(mk(2'b10, 6'b000110, 32'h00000004, 32'h80000000, 1'b0, 6'b001001, 32'h08000000, 3'b000));
    vecs.push_back(mk(2'b10, 6'b000100, 32'h00000000, 32'h80000000, 1'b0, 6'b001000, 32'h80000000, 3'b000));
    vecs.push_back(mk(2'b10, 6'b111111, 32'h00000005, 32'h00000006, 1'b0, 6'b111111, 32'h00000000, 3'b100));
    vecs.push_back(mk(2'b11, 6'b000000, 32'h000000F0, 32'h0000000F, 1'b0, 6'b000001, 32'h000000FF, 3'b000));
    vecs.push_back(mk(2'b10, 6'b100010, 32'h80000000, 32'h00000001, 1'b0, 6'b000110, 32'h7FFFFFFF, 3'b011));
    vecs.push_back(mk(2'b00, 6'b000000, 32'hFFFFFFFF, 32'h00000001, 1'b1, 6'b000010, 32'h00000000, 3'b110));
    vecs.push_back(mk(2'b10, 6'b100100, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 6'b000000, 32'h0F000F00, 3'b000));
    vecs.push_back(mk(2'b10, 6'b100110, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 6'b000011, 32'hF00FF00F, 3'b000));
    vecs.push_back(mk(2'b10, 6'b100111, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 6'b001100, 32'h00F000F0, 3'b000));
    vecs.push_back(mk(2'b10, 6'b100101, 32'h00000001, 32'h00000002, 1'b0, 6'b000001, 32'h00000003, 3'b000));
    vecs.push_back(mk(2'b10, 6'b100001, 32'h00000001, 32'h00000002, 1'b0, 6'b000010, 32'h00000003, 3'b000));
    vecs.push_back(mk(2'b10, 6'b100011, 32'h00000001, 32'h00000002, 1'b1, 6'b000110, 32'hFFFFFFFF, 3'b000));
    vecs.push_back(mk(2'b10, 6'b000100, 32'h0000001F, 32'h00000001, 1'b0, 6'b001000, 32'h80000000, 3'b000));
    vecs.push_back(mk(2'b10, 6'b000111, 32'h0000001F, 32'h80000000, 1'b0, 6'b001010, 32'hFFFFFFFF, 3'b000));
    vecs.push_back(mk(2'b10, 6'b000110, 32'h0000001F, 32'h80000000, 1'b0, 6'b001001, 32'h00000001, 3'b000));
    vecs.push_back(mk(2'b10, 6'b001000, 32'h00000003, 32'h00000004, 1'b1, 6'b111111, 32'h00000000, 3'b100));
    vecs.push_back(mk(2'b10, 6'b101010, 32'h00000001, 32'hFFFFFFFF, 1'b0, 6'b000111, 32'h00000000, 3'b100));
    vecs.push_back(mk(2'b00, 6'b000000, 32'h80000000, 32'h80000000, 1'b0, 6'b000010, 32'h00000000, 3'b111));
    vecs.push_back(mk(2'b10, 6'b000111, 32'h00000000, 32'h12345678, 1'b0, 6'b001010, 32'h12345678, 3'b000));
    vecs.push_back(mk(2'b10, 6'b100000, 32'h00000010, 32'h00000020, 1'b1, 6'b000010, 32'h00000030, 3'b000));

    // Reset state while reset is held low
    #2;
    chk("reset mem_result", mem_result, 32'd0);
    chk("reset mem_flags", {29'd0, mem_flags}, 32'd0);
    chk("reset do_branch", {31'd0, do_branch}, 32'd0);
    #6;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Registers hold nonzero data now; async reset mid-cycle must clear them at once
    chk("pre-reset mem_result", {31'd0, (mem_result != 32'd0)}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async mem_result", mem_result, 32'd0);
    chk("async mem_flags", {29'd0, mem_flags}, 32'd0);
    chk("async mem_branch", {31'd0, mem_branch}, 32'd0);
    chk("async do_branch", {31'd0, do_branch}, 32'd0);
    @(posedge clk);
    #1;
    chk("held mem_result", mem_result, 32'd0);
    chk("held mem_branch", {31'd0, mem_branch}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    // First load after release: beq-style equal compare with branch set
    apply(mk(2'b01, 6'b000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 6'b000110, 32'h00000000, 3'b110), 100);
    apply(mk(2'b00, 6'b000000, 32'h00000002, 32'h00000003, 1'b0, 6'b000010, 32'h00000005, 3'b000), 101);

    chk("scoreboard empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
